// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-GR busy/latency tracking, RAW/WAW interlocks,
// divider and store->load ordering stalls, and a saturating stall counter.
module hazard_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_i,
    input  logic             set_i,
    input  logic [LAT_W-1:0] set_lat_i,
    input  logic             dec_en_i,
    input  logic             wb_hit_i,
    output logic             busy_o,
    output logic             long_o,
    output logic [LAT_W-1:0] cnt_o
);
    logic             busy_q, busy_d;
    logic             long_q, long_d;
    logic [LAT_W-1:0] cnt_q,  cnt_d;

    always_comb begin
        busy_d = busy_q;
        long_d = long_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            busy_d = 1'b0;
            long_d = 1'b0;
            cnt_d  = '0;
        end else if (set_i) begin
            // a fresh issue overrides any retire/decrement landing on the same edge
            busy_d = 1'b1;
            long_d = (set_lat_i == '0);
            cnt_d  = set_lat_i;
        end else if (long_q) begin
            if (wb_hit_i) begin
                busy_d = 1'b0;
                long_d = 1'b0;
            end
        end else if (dec_en_i && cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
            if (cnt_q == LAT_W'(1))
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            long_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            long_q <= long_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o = busy_q;
    assign long_o = long_q;
    assign cnt_o  = cnt_q;
endmodule

module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              is_valid,
    input  logic [REG_AW-1:0] is_rj,
    input  logic              is_rj_used,
    input  logic [REG_AW-1:0] is_rkd,
    input  logic              is_rkd_used,
    input  logic              is_gr_we,
    input  logic [REG_AW-1:0] is_dest,
    input  logic [LAT_W-1:0]  is_lat,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              es_div_busy,
    input  logic              es_has_ld,
    input  logic              ms_has_st,
    input  logic              pipe_flush,
    output logic              is_stall,
    output logic              es_stall,
    output logic              es_flush,
    output logic              ms_flush,
    output logic [PERF_W-1:0] perf_stall_cnt
);
    logic [NREG-1:0]            busy;
    logic [NREG-1:0]            is_long;
    logic [NREG-1:0][LAT_W-1:0] cnt;
    logic                       issue;
    logic                       haz_rj, haz_rkd, haz_waw;
    logic [PERF_W-1:0]          perf_q, perf_d;

    assign busy[0]    = 1'b0;
    assign is_long[0] = 1'b0;
    assign cnt[0]     = '0;

    // flush suppresses recording of the instruction sitting in IS
    assign issue = is_valid & ~is_stall & ~pipe_flush;

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        hazard_sb_entry #(.LAT_W(LAT_W)) u_ent (
            .clk       (clk),
            .resetn    (resetn),
            .flush_i   (pipe_flush),
            .set_i     (issue & is_gr_we & (is_dest == REG_AW'(r))),
            .set_lat_i (is_lat),
            .dec_en_i  (~es_stall),
            .wb_hit_i  (wb_valid & (wb_dest == REG_AW'(r))),
            .busy_o    (busy[r]),
            .long_o    (is_long[r]),
            .cnt_o     (cnt[r])
        );
    end

    // cnt==1 means the result is on the bypass next cycle, so it does not stall
    assign haz_rj  = is_rj_used & (is_rj != '0) & busy[is_rj] &
                     (is_long[is_rj] | (cnt[is_rj] > LAT_W'(1)));
    assign haz_rkd = is_rkd_used & (is_rkd != '0) & busy[is_rkd] &
                     (is_long[is_rkd] | (cnt[is_rkd] > LAT_W'(1)));
    assign haz_waw = is_gr_we & (is_dest != '0) & busy[is_dest] & is_long[is_dest];

    always_comb begin
        is_stall = 1'b0;
        es_stall = 1'b0;
        es_flush = 1'b0;
        ms_flush = 1'b0;
        if (pipe_flush) begin
            is_stall = 1'b0;
        end else if (es_div_busy || (es_has_ld && ms_has_st)) begin
            is_stall = 1'b1;
            es_stall = 1'b1;
            ms_flush = 1'b1;
        end else if (is_valid && (haz_rj || haz_rkd || haz_waw)) begin
            is_stall = 1'b1;
            es_flush = 1'b1;
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (is_stall && perf_q != {PERF_W{1'b1}})
            perf_d = perf_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) perf_q <= '0;
        else         perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
endmodule
